// File: rtl/bus_dev_endpoint_if.sv
// Bus-facing side of a device slot: TX head offered via pndng/D_pop/pop,
// RX delivery via push/D_push.
interface bus_dev_endpoint_if #(
  parameter int pckg_sz = 32
);
  logic               pndng;
  logic [pckg_sz-1:0] D_pop;
  logic               pop;
  logic               push;
  logic [pckg_sz-1:0] D_push;

  // bus arbiter side
  modport master (input pndng, D_pop, output pop, push, D_push);
  // device endpoint side
  modport slave  (output pndng, D_pop, input pop, push, D_push);
endinterface

// File: rtl/bus_dev_endpoint.sv
// Device endpoint: FWFT TX FIFO toward the bus, FWFT RX FIFO from the bus, sticky error flags.
// Optional RX destination filter enabled with macro RX_FILTER_EN.
module bus_dev_endpoint #(
  parameter int         pckg_sz   = 32,
  parameter int         depth     = 8,
  parameter logic [7:0] id        = 8'd0,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       tx_wr,
  input  logic [pckg_sz-1:0]         tx_data,
  output logic                       tx_full,
  output logic [$clog2(depth+1)-1:0] tx_count,
  bus_dev_endpoint_if.slave          bus,
  input  logic                       rx_rd,
  output logic [pckg_sz-1:0]         rx_data,
  output logic                       rx_valid,
  output logic [$clog2(depth+1)-1:0] rx_count,
  input  logic                       clr_flags,
  output logic                       tx_ovf,
  output logic                       rx_ovf,
  output logic                       pop_err
);
  localparam int AW = $clog2(depth);
  localparam int CW = $clog2(depth+1);

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_PARTIAL = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

  logic [pckg_sz-1:0] tx_mem_q [depth];
  logic [pckg_sz-1:0] tx_mem_d [depth];
  logic [pckg_sz-1:0] rx_mem_q [depth];
  logic [pckg_sz-1:0] rx_mem_d [depth];
  logic [AW:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [AW:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d, pop_err_q, pop_err_d;

  logic [1:0] tx_state, rx_state;
  logic [AW:0] tx_occ, rx_occ;
  logic tx_do_wr, tx_do_pop, rx_hit, rx_do_wr, rx_do_rd;

  // Occupancy-driven state: the wrap bit distinguishes full from empty.
  always_comb begin
    tx_occ = tx_wp_q - tx_rp_q;
    rx_occ = rx_wp_q - rx_rp_q;
    if (tx_wp_q == tx_rp_q)
      tx_state = ST_EMPTY;
    else if (tx_wp_q[AW-1:0] == tx_rp_q[AW-1:0])
      tx_state = ST_FULL;
    else
      tx_state = ST_PARTIAL;
    if (rx_wp_q == rx_rp_q)
      rx_state = ST_EMPTY;
    else if (rx_wp_q[AW-1:0] == rx_rp_q[AW-1:0])
      rx_state = ST_FULL;
    else
      rx_state = ST_PARTIAL;
  end

`ifdef RX_FILTER_EN
  assign rx_hit = (bus.D_push[pckg_sz-1:pckg_sz-8] == id) ||
                  (bus.D_push[pckg_sz-1:pckg_sz-8] == broadcast);
`else
  assign rx_hit = 1'b1;
`endif

  // A same-cycle pop/read frees a slot for a write into a full FIFO.
  always_comb begin
    tx_do_pop = bus.pop && (tx_state != ST_EMPTY);
    tx_do_wr  = tx_wr && ((tx_state != ST_FULL) || bus.pop);
    rx_do_rd  = rx_rd && (rx_state != ST_EMPTY);
    rx_do_wr  = bus.push && rx_hit && ((rx_state != ST_FULL) || rx_rd);

    tx_wp_d = tx_wp_q + {{AW{1'b0}}, tx_do_wr};
    tx_rp_d = tx_rp_q + {{AW{1'b0}}, tx_do_pop};
    rx_wp_d = rx_wp_q + {{AW{1'b0}}, rx_do_wr};
    rx_rp_d = rx_rp_q + {{AW{1'b0}}, rx_do_rd};

    tx_mem_d = tx_mem_q;
    rx_mem_d = rx_mem_q;
    if (tx_do_wr) tx_mem_d[tx_wp_q[AW-1:0]] = tx_data;
    if (rx_do_wr) rx_mem_d[rx_wp_q[AW-1:0]] = bus.D_push;
  end

  // Clear first, then a same-cycle error event re-sets the flag.
  always_comb begin
    tx_ovf_d  = clr_flags ? 1'b0 : tx_ovf_q;
    rx_ovf_d  = clr_flags ? 1'b0 : rx_ovf_q;
    pop_err_d = clr_flags ? 1'b0 : pop_err_q;
    if (tx_wr && !tx_do_wr)                  tx_ovf_d  = 1'b1;
    if (bus.push && rx_hit && !rx_do_wr)     rx_ovf_d  = 1'b1;
    if (bus.pop && (tx_state == ST_EMPTY))   pop_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wp_q   <= '0;
      tx_rp_q   <= '0;
      rx_wp_q   <= '0;
      rx_rp_q   <= '0;
      tx_ovf_q  <= 1'b0;
      rx_ovf_q  <= 1'b0;
      pop_err_q <= 1'b0;
    end else begin
      tx_wp_q   <= tx_wp_d;
      tx_rp_q   <= tx_rp_d;
      rx_wp_q   <= rx_wp_d;
      rx_rp_q   <= rx_rp_d;
      tx_ovf_q  <= tx_ovf_d;
      rx_ovf_q  <= rx_ovf_d;
      pop_err_q <= pop_err_d;
    end
  end

  // Storage needs no reset: outputs are masked whenever a FIFO is empty.
  always_ff @(posedge clk) begin
    tx_mem_q <= tx_mem_d;
    rx_mem_q <= rx_mem_d;
  end

  assign bus.pndng = (tx_state != ST_EMPTY);
  assign bus.D_pop = (tx_state != ST_EMPTY) ? tx_mem_q[tx_rp_q[AW-1:0]] : '0;
  assign tx_full   = (tx_state == ST_FULL);
  assign tx_count  = CW'(tx_occ);
  assign rx_valid  = (rx_state != ST_EMPTY);
  assign rx_data   = (rx_state != ST_EMPTY) ? rx_mem_q[rx_rp_q[AW-1:0]] : '0;
  assign rx_count  = CW'(rx_occ);
  assign tx_ovf    = tx_ovf_q;
  assign rx_ovf    = rx_ovf_q;
  assign pop_err   = pop_err_q;
endmodule

// File: tb/tb_bus_dev_endpoint.sv
// Directed self-checking bench for bus_dev_endpoint (depth=8, id=3); follows RX_FILTER_EN if defined.
module tb_bus_dev_endpoint;
  localparam int PW = 32;
  localparam int DP = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          tx_wr;
  logic [PW-1:0] tx_data;
  logic          tx_full;
  logic [3:0]    tx_count;
  logic          rx_rd;
  logic [PW-1:0] rx_data;
  logic          rx_valid;
  logic [3:0]    rx_count;
  logic          clr_flags;
  logic          tx_ovf, rx_ovf, pop_err;

  int errs   = 0;
  int checks = 0;

  bus_dev_endpoint_if #(.pckg_sz(PW)) bus_if ();

  bus_dev_endpoint #(.pckg_sz(PW), .depth(DP), .id(8'd3), .broadcast(8'hFF)) dut (
    .clk(clk), .reset(reset),
    .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full), .tx_count(tx_count),
    .bus(bus_if.slave),
    .rx_rd(rx_rd), .rx_data(rx_data), .rx_valid(rx_valid), .rx_count(rx_count),
    .clr_flags(clr_flags), .tx_ovf(tx_ovf), .rx_ovf(rx_ovf), .pop_err(pop_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tx_wr = 0; tx_data = '0; rx_rd = 0; clr_flags = 0;
    bus_if.pop = 0; bus_if.push = 0; bus_if.D_push = '0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1; tick(); reset = 0;
    checks++; if (bus_if.pndng !== 1'b0) begin errs++; $display("FAIL rst_pndng got=%0b exp=0", bus_if.pndng); end
    checks++; if (bus_if.D_pop !== 32'h0) begin errs++; $display("FAIL rst_dpop got=%h exp=0", bus_if.D_pop); end
    checks++; if (rx_valid !== 1'b0 || rx_data !== 32'h0) begin errs++; $display("FAIL rst_rx got=%0b/%h exp=0/0", rx_valid, rx_data); end
    checks++; if (tx_full !== 1'b0 || tx_count !== 4'd0 || rx_count !== 4'd0) begin errs++; $display("FAIL rst_counts got full=%0b tx=%0d rx=%0d exp=0/0/0", tx_full, tx_count, rx_count); end
    checks++; if ({tx_ovf, rx_ovf, pop_err} !== 3'b000) begin errs++; $display("FAIL rst_flags got=%b exp=000", {tx_ovf, rx_ovf, pop_err}); end
  endtask

  task automatic test_tx_basic();
    tx_wr = 1; tx_data = 32'h0312_3456; tick(); tx_wr = 0;
    checks++; if (bus_if.pndng !== 1'b1 || bus_if.D_pop !== 32'h0312_3456) begin errs++; $display("FAIL tx_first got=%0b/%h exp=1/03123456", bus_if.pndng, bus_if.D_pop); end
    checks++; if (tx_count !== 4'd1) begin errs++; $display("FAIL tx_cnt1 got=%0d exp=1", tx_count); end
    bus_if.pop = 1; tick(); bus_if.pop = 0;
    checks++; if (bus_if.pndng !== 1'b0 || bus_if.D_pop !== 32'h0 || tx_count !== 4'd0) begin errs++; $display("FAIL tx_popped got=%0b/%h/%0d exp=0/0/0", bus_if.pndng, bus_if.D_pop, tx_count); end
  endtask

  // Pointers start at 1 here, so the fill and drain cross the wrap.
  task automatic test_tx_full();
    logic [PW-1:0] exp_q [$];
    for (int i = 0; i < 8; i++) begin
      tx_wr = 1; tx_data = PW'(i); tick();
    end
    tx_wr = 0;
    checks++; if (tx_full !== 1'b1 || tx_count !== 4'd8) begin errs++; $display("FAIL tx_full got=%0b/%0d exp=1/8", tx_full, tx_count); end
    tx_wr = 1; tx_data = 32'h8; tick(); tx_wr = 0;
    checks++; if (tx_ovf !== 1'b1 || tx_count !== 4'd8 || bus_if.D_pop !== 32'h0) begin errs++; $display("FAIL tx_drop got ovf=%0b cnt=%0d head=%h exp=1/8/0", tx_ovf, tx_count, bus_if.D_pop); end
    tx_wr = 1; tx_data = 32'h9; bus_if.pop = 1; tick(); tx_wr = 0; bus_if.pop = 0;
    checks++; if (tx_count !== 4'd8 || tx_full !== 1'b1 || bus_if.D_pop !== 32'h1) begin errs++; $display("FAIL tx_wr_pop got cnt=%0d full=%0b head=%h exp=8/1/1", tx_count, tx_full, bus_if.D_pop); end
    exp_q = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h9};
    foreach (exp_q[i]) begin
      checks++; if (bus_if.D_pop !== exp_q[i] || bus_if.pndng !== 1'b1) begin errs++; $display("FAIL tx_drain[%0d] got=%h/%0b exp=%h/1", i, bus_if.D_pop, bus_if.pndng, exp_q[i]); end
      bus_if.pop = 1; tick(); bus_if.pop = 0;
    end
    checks++; if (bus_if.pndng !== 1'b0 || tx_count !== 4'd0 || tx_ovf !== 1'b1) begin errs++; $display("FAIL tx_drained got=%0b/%0d/ovf%0b exp=0/0/1", bus_if.pndng, tx_count, tx_ovf); end
    clr_flags = 1; tick(); clr_flags = 0;
    checks++; if (tx_ovf !== 1'b0) begin errs++; $display("FAIL tx_ovf_clr got=%0b exp=0", tx_ovf); end
  endtask

  task automatic test_pop_err();
    bus_if.pop = 1; tick(); bus_if.pop = 0;
    checks++; if (pop_err !== 1'b1 || tx_count !== 4'd0) begin errs++; $display("FAIL pop_err_set got=%0b/%0d exp=1/0", pop_err, tx_count); end
    tx_wr = 1; tx_data = 32'hA5A5_0001; tick(); tx_wr = 0;
    checks++; if (bus_if.D_pop !== 32'hA5A5_0001 || tx_count !== 4'd1) begin errs++; $display("FAIL pop_err_ptr got=%h/%0d exp=a5a50001/1", bus_if.D_pop, tx_count); end
    bus_if.pop = 1; tick(); bus_if.pop = 0;
    clr_flags = 1; tick(); clr_flags = 0;
    checks++; if (pop_err !== 1'b0) begin errs++; $display("FAIL pop_err_clr got=%0b exp=0", pop_err); end
    clr_flags = 1; bus_if.pop = 1; tick(); clr_flags = 0; bus_if.pop = 0;
    checks++; if (pop_err !== 1'b1) begin errs++; $display("FAIL pop_err_clr_win got=%0b exp=1", pop_err); end
    clr_flags = 1; tick(); clr_flags = 0;
  endtask

  task automatic test_rx_filter();
`ifdef RX_FILTER_EN
    bus_if.push = 1; bus_if.D_push = 32'h0300_00AA; tick();
    checks++; if (rx_valid !== 1'b1 || rx_data !== 32'h0300_00AA) begin errs++; $display("FAIL rx_own got=%0b/%h exp=1/030000aa", rx_valid, rx_data); end
    bus_if.D_push = 32'hFF00_00BB; tick();
    checks++; if (rx_count !== 4'd2) begin errs++; $display("FAIL rx_bcast got=%0d exp=2", rx_count); end
    bus_if.D_push = 32'h0500_00CC; tick(); bus_if.push = 0;
    checks++; if (rx_count !== 4'd2 || rx_ovf !== 1'b0) begin errs++; $display("FAIL rx_filtered got=%0d/ovf%0b exp=2/0", rx_count, rx_ovf); end
    rx_rd = 1; tick(); rx_rd = 0;
    checks++; if (rx_data !== 32'hFF00_00BB || rx_count !== 4'd1) begin errs++; $display("FAIL rx_order got=%h/%0d exp=ff0000bb/1", rx_data, rx_count); end
`else
    bus_if.push = 1; bus_if.D_push = 32'h0500_00CC; tick(); bus_if.push = 0;
    checks++; if (rx_valid !== 1'b1 || rx_data !== 32'h0500_00CC || rx_count !== 4'd1) begin errs++; $display("FAIL rx_nofilter got=%0b/%h/%0d exp=1/050000cc/1", rx_valid, rx_data, rx_count); end
`endif
    rx_rd = 1; for (int i = 0; i < 4; i++) tick(); rx_rd = 0;
    checks++; if (rx_valid !== 1'b0 || rx_data !== 32'h0 || rx_count !== 4'd0) begin errs++; $display("FAIL rx_empty got=%0b/%h/%0d exp=0/0/0", rx_valid, rx_data, rx_count); end
  endtask

  task automatic test_rx_full();
    logic [PW-1:0] exp_q [$];
    bus_if.push = 1;
    for (int i = 0; i < 8; i++) begin
      bus_if.D_push = 32'h0300_0010 + PW'(i); tick();
    end
    bus_if.push = 0;
    checks++; if (rx_count !== 4'd8) begin errs++; $display("FAIL rx_fill got=%0d exp=8", rx_count); end
    bus_if.push = 1; bus_if.D_push = 32'h0300_0020; tick(); bus_if.push = 0;
    checks++; if (rx_ovf !== 1'b1 || rx_count !== 4'd8 || rx_data !== 32'h0300_0010) begin errs++; $display("FAIL rx_drop got ovf=%0b cnt=%0d head=%h exp=1/8/03000010", rx_ovf, rx_count, rx_data); end
    bus_if.push = 1; bus_if.D_push = 32'h0300_0021; rx_rd = 1; tick(); bus_if.push = 0; rx_rd = 0;
    checks++; if (rx_count !== 4'd8 || rx_data !== 32'h0300_0011) begin errs++; $display("FAIL rx_push_rd got cnt=%0d head=%h exp=8/03000011", rx_count, rx_data); end
    exp_q = '{32'h0300_0011, 32'h0300_0012, 32'h0300_0013, 32'h0300_0014,
              32'h0300_0015, 32'h0300_0016, 32'h0300_0017, 32'h0300_0021};
    foreach (exp_q[i]) begin
      checks++; if (rx_data !== exp_q[i] || rx_valid !== 1'b1) begin errs++; $display("FAIL rx_drain[%0d] got=%h/%0b exp=%h/1", i, rx_data, rx_valid, exp_q[i]); end
      rx_rd = 1; tick(); rx_rd = 0;
    end
    checks++; if (rx_valid !== 1'b0 || rx_count !== 4'd0) begin errs++; $display("FAIL rx_drained got=%0b/%0d exp=0/0", rx_valid, rx_count); end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 5; i++) begin
      tx_wr = 1; tx_data = 32'h0700_0000 + PW'(i); tick();
    end
    tx_wr = 0;
    bus_if.push = 1;
    for (int i = 0; i < 3; i++) begin
      bus_if.D_push = 32'hFF00_0030 + PW'(i); tick();
    end
    bus_if.push = 0;
    checks++; if (tx_count !== 4'd5 || rx_count !== 4'd3 || rx_ovf !== 1'b1) begin errs++; $display("FAIL pre_rst got tx=%0d rx=%0d rxovf=%0b exp=5/3/1", tx_count, rx_count, rx_ovf); end
    reset = 1; tx_wr = 1; bus_if.push = 1; bus_if.pop = 1; tick();
    reset = 0; idle();
    checks++; if (tx_count !== 4'd0 || rx_count !== 4'd0 || bus_if.pndng !== 1'b0 || rx_valid !== 1'b0) begin errs++; $display("FAIL mid_rst got tx=%0d rx=%0d pndng=%0b rxv=%0b exp=0/0/0/0", tx_count, rx_count, bus_if.pndng, rx_valid); end
    checks++; if (bus_if.D_pop !== 32'h0 || {tx_ovf, rx_ovf, pop_err} !== 3'b000) begin errs++; $display("FAIL mid_rst_flags got dpop=%h flags=%b exp=0/000", bus_if.D_pop, {tx_ovf, rx_ovf, pop_err}); end
  endtask

  initial begin
    idle();
    reset = 1;
    tick();
    test_reset();
    test_tx_basic();
    test_tx_full();
    test_pop_err();
    test_rx_filter();
    clr_flags = 1; tick(); clr_flags = 0;
    test_rx_full();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout bench did not finish");
    $fatal(1);
  end
endmodule

// File: doc/bus_dev_endpoint.md
Name: bus_dev_endpoint

Overview:
Device-side endpoint for the bs_gnrtr_n_rbtr bus, one instance per device slot. Its TX FIFO presents outbound packets to the bus through pndng, D_pop and pop. Its RX FIFO absorbs packets the bus delivers through push and D_push. The local client loads and drains these FIFOs with a simple write/read interface. This replaces the behavioural FIFO model in the bench drivers with synthesizable RTL.

Parameters:
pckg_sz, 32, packet width in bits; bits [pckg_sz-1:pckg_sz-8] hold the destination ID
depth, 8, entries per FIFO (TX and RX), power of 2, minimum 2
id, 0, this device's 8-bit ID (0 to 254)
broadcast, 8'hFF, destination ID accepted by every device

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
tx_wr  in  1  client write strobe into TX FIFO
tx_data  in  pckg_sz  client packet to send
tx_full  out  1  TX FIFO full
tx_count  out  $clog2(depth+1)  TX occupancy
pndng  out  1  TX FIFO non-empty (bus-facing)
D_pop  out  pckg_sz  TX head packet (bus-facing)
pop  in  1  bus consumes TX head
push  in  1  bus delivers packet
D_push  in  pckg_sz  delivered packet
rx_rd  in  1  client read strobe
rx_data  out  pckg_sz  RX head packet
rx_valid  out  1  RX FIFO non-empty
rx_count  out  $clog2(depth+1)  RX occupancy
clr_flags  in  1  clears sticky flags
tx_ovf  out  1  sticky: tx_wr dropped because TX full
rx_ovf  out  1  sticky: push dropped because RX full
pop_err  out  1  sticky: pop while TX empty

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset. At a rising edge with reset=1, both FIFOs empty and pointers 0.
- Outputs after reset: pndng=0, D_pop=0, rx_valid=0, rx_data=0, tx_full=0, counts=0, all sticky flags 0. Reset has priority over every other input in the same cycle.
- Reset mid-operation discards all stored packets. No partial state survives.
- Both FIFOs are first-word fall-through.
- D_pop is the TX head whenever pndng=1, and is forced to 0 when the TX FIFO is empty. rx_data follows the same rule with rx_valid.
- Latency: tx_wr sampled at edge N gives pndng=1 and D_pop valid after edge N (one cycle). An accepted push at edge N gives rx_valid=1 after edge N.
- TX write: accepted if not full, or if full and pop=1 in the same cycle (pop frees the slot first). Otherwise the packet is dropped and tx_ovf is set. tx_count is unchanged on a simultaneous accepted write and pop.
- TX pop: advances the read pointer if non-empty. If empty, it is ignored and pop_err is set.
- RX accept (filter per Optional Feature): stored if not full, or if full with rx_rd=1 in the same cycle. Otherwise dropped and rx_ovf is set.
- rx_rd while empty is ignored silently.
- Pointers are log2(depth) bits wide with a separate wrap bit. Full when addresses are equal and wrap bits differ; empty when both are equal. Wrap-around is seamless with no bubble.
- Flag priority: clr_flags clears the sticky flags at the edge. A new error event in the same cycle wins, so the flag stays set.
- Own packets are not looped back: a push with source = this device is not this block's concern; the bus defines routing.
- Operating states per FIFO: EMPTY, PARTIAL, FULL, driven by occupancy. No other FSM.

Optional Feature:
Macro RX_FILTER_EN.
- Defined: a push is accepted only if D_push[pckg_sz-1:pckg_sz-8] == id or == broadcast. Non-matching pushes are dropped silently and do not set rx_ovf.
- Undefined: every push is accepted (the bus is trusted to route), and the ID comparison logic is absent.

Test Plan:
- Reset, then tx_wr with tx_data=32'h0312_3456 -> next cycle pndng=1, D_pop=32'h0312_3456, tx_count=1. Pulse pop -> pndng=0, D_pop=0.
- Write 8 packets 32'h0000_0000..32'h0000_0007 (depth=8) -> tx_full=1. A 9th tx_wr without pop -> dropped, tx_ovf=1. A 9th tx_wr with pop in the same cycle -> accepted, tx_count stays 8. Draining yields the packets in order across pointer wrap.
- pop with TX empty -> pop_err=1, pointers unchanged. clr_flags -> pop_err=0. clr_flags together with a new empty pop -> pop_err stays 1.
- With RX_FILTER_EN and id=3:
  - push D_push=32'h0300_00AA -> rx_valid=1, rx_data=32'h0300_00AA.
  - push 32'hFF00_00BB -> accepted.
  - push 32'h0500_00CC -> dropped, rx_count=2, rx_ovf=0.
- Without the macro, push 32'h0500_00CC -> accepted.
- Fill RX to 8, then push -> dropped, rx_ovf=1. Fill RX to 8, then push with rx_rd in the same cycle -> accepted, rx_count stays 8.
- Assert reset with TX=5 and RX=3 entries -> after the edge all counts=0, pndng=0, rx_valid=0, D_pop=0, flags=0.
